inta_sequencer: RTL and testbench



---
 rtl/pic_pkg.sv | 36 +++
 rtl/sync_bit.sv | 40 ++++
 rtl/inta_sequencer.sv | 210 +++++++++++++++++++++
 tb/tb_inta_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the interrupt controller slice: the interrupt
// acknowledge FSM state encoding, the vector width, and the default pulse
// and gap timing. The defaults are shared so the PIC bench and the
// sequencer agree on NINTA timing.
// ---------------------------------------------------------------------------
package pic_pkg;

   localparam int VEC_W            = 8;
   localparam int DEF_PULSE_CYCLES = 2;
   localparam int DEF_GAP_CYCLES   = 1;
   localparam int DEF_SYNC_STAGES  = 2;

   // Acknowledge sequence states. P1/P2 are the two NINTA low pulses, G1 is
   // the high gap between them, HOLD waits for the CPU to take the vector,
   // and RECOVER lets the synchronizer flush the stale request.
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      P1      = 3'd1,
      G1      = 3'd2,
      P2      = 3'd3,
      HOLD    = 3'd4,
      RECOVER = 3'd5
   } inta_state_e;

   // Largest of three timing parameters; sizes the shared down-counter.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// ---------------------------------------------------------------------------
// sync_bit
// Single-bit synchronizer: a STAGES-deep flop chain that brings an
// asynchronous level into the clk domain. The chain clears on reset.
// Used for the PIC INT line here, and reusable for the PIC IR inputs.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-high reset
//   d      in   asynchronous input level
//   q      out  synchronized level, STAGES clocks after d
// ---------------------------------------------------------------------------
module sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the input in at bit 0; the oldest sample leaves at the top.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/inta_sequencer.sv
// ---------------------------------------------------------------------------
// inta_sequencer
// CPU-side interrupt acknowledge engine for an 8259A-style PIC. It
// synchronizes INT, runs the two-pulse NINTA acknowledge cycle, captures
// the vector from D at the end of the second pulse, and offers it to the
// CPU over a valid/ready handshake.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   INT        in   interrupt request from the PIC (asynchronous)
//   ien        in   CPU interrupt enable, gates only the start of a sequence
//   D          in   PIC data bus, sampled at the end of the second pulse
//   NINTA      out  active-low acknowledge to the PIC (registered)
//   vec_valid  out  captured vector available
//   vec_data   out  captured vector
//   vec_ready  in   CPU accepts the vector
//   busy       out  high whenever the FSM is not IDLE
//   spurious   out  vector was acknowledged after the request was withdrawn
//
// Build option:
//   INTA_SPURIOUS_CHK_EN  when defined, the synchronized request is sampled
//                         in the first P1 cycle and spurious reports a
//                         withdrawn request alongside the vector. When not
//                         defined, spurious is tied low.
// ---------------------------------------------------------------------------
module inta_sequencer
   import pic_pkg::*;
#(
   parameter int PULSE_CYCLES = DEF_PULSE_CYCLES,
   parameter int GAP_CYCLES   = DEF_GAP_CYCLES,
   parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             INT,
   input  logic             ien,
   input  logic [VEC_W-1:0] D,
   output logic             NINTA,
   output logic             vec_valid,
   output logic [VEC_W-1:0] vec_data,
   input  logic             vec_ready,
   output logic             busy,
   output logic             spurious
);

   localparam int CNT_W = $clog2(max3(PULSE_CYCLES, GAP_CYCLES, SYNC_STAGES)) + 1;

   // Counter load values: each timed state runs until the counter hits zero,
   // so loading N-1 gives exactly N cycles in that state.
   localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] SYNC_LOAD  = CNT_W'(SYNC_STAGES - 1);

   logic int_s;

   inta_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ninta_q, ninta_d;
   logic             valid_q, valid_d;
   logic [VEC_W-1:0] data_q, data_d;

   logic cnt_done;
   logic capture;
   logic handshake;

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_int_sync (
      .clk   (clk),
      .reset (reset),
      .d     (INT),
      .q     (int_s)
   );

   assign cnt_done  = (cnt_q == '0);
   assign capture   = (state_q == P2) && cnt_done;
   assign handshake = (state_q == HOLD) && vec_ready;

   // Next-state and registered-output logic. NINTA is computed one edge
   // ahead so the pin comes straight from a flop. vec_ready only matters in
   // HOLD, which is the only state where the vector is valid.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ninta_d = ninta_q;
      valid_d = valid_q;
      data_d  = data_q;

      case (state_q)
         IDLE: begin
            if (int_s && ien) begin
               state_d = P1;
               cnt_d   = PULSE_LOAD;
               ninta_d = 1'b0;
            end
         end
         P1: begin
            if (cnt_done) begin
               state_d = G1;
               cnt_d   = GAP_LOAD;
               ninta_d = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         G1: begin
            if (cnt_done) begin
               state_d = P2;
               cnt_d   = PULSE_LOAD;
               ninta_d = 1'b0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         P2: begin
            if (cnt_done) begin
               state_d = HOLD;
               ninta_d = 1'b1;
               valid_d = 1'b1;
               data_d  = D;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         HOLD: begin
            if (vec_ready) begin
               state_d = RECOVER;
               cnt_d   = SYNC_LOAD;
               valid_d = 1'b0;
            end
         end
         RECOVER: begin
            // int_s still reflects the request that was just acknowledged;
            // ignore it until the synchronizer has had time to flush.
            if (cnt_done) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            ninta_d = 1'b1;
            valid_d = 1'b0;
         end
      endcase
   end

   // Reset drives NINTA high immediately and drops any partial vector.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ninta_q <= 1'b1;
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ninta_q <= ninta_d;
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

`ifdef INTA_SPURIOUS_CHK_EN
   logic req_seen_q, req_seen_d;
   logic spur_q, spur_d;

   // The request is checked once, in the first P1 cycle (counter still at
   // its load value). A low request there means the PIC withdrew INT after
   // we committed; the pair still completes and the vector is flagged.
   always_comb begin
      req_seen_d = req_seen_q;
      spur_d     = spur_q;
      if ((state_q == P1) && (cnt_q == PULSE_LOAD)) begin
         req_seen_d = int_s;
      end
      if (capture) begin
         spur_d = ~req_seen_q;
      end else if (handshake) begin
         spur_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_seen_q <= 1'b0;
         spur_q     <= 1'b0;
      end else begin
         req_seen_q <= req_seen_d;
         spur_q     <= spur_d;
      end
   end

   assign spurious = spur_q;
`else
   logic unused_flags;
   assign unused_flags = capture ^ handshake;
   assign spurious     = 1'b0;
`endif

   assign NINTA     = ninta_q;
   assign vec_valid = valid_q;
   assign vec_data  = data_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_inta_sequencer.sv
// ---------------------------------------------------------------------------
// tb_inta_sequencer
// Self-checking bench for inta_sequencer with default timing. Expected
// vectors are pushed to a scoreboard queue when a request is driven and
// popped when the DUT raises vec_valid. A table of vectors covers the plain
// acknowledge path; hand-written sequences cover reset, NINTA timing,
// backpressure, enable gating, back-to-back requests and the withdrawn
// request case.
// ---------------------------------------------------------------------------
module tb_inta_sequencer;
   import pic_pkg::*;

   localparam int PULSE = DEF_PULSE_CYCLES;
   localparam int GAP   = DEF_GAP_CYCLES;
   localparam int SYNC  = DEF_SYNC_STAGES;
   localparam int WAIT_LIMIT = 60;

`ifdef INTA_SPURIOUS_CHK_EN
   localparam logic SPUR_EN = 1'b1;
`else
   localparam logic SPUR_EN = 1'b0;
`endif

   logic             clk;
   logic             reset;
   logic             INT;
   logic             ien;
   logic [VEC_W-1:0] D;
   logic             NINTA;
   logic             vec_valid;
   logic [VEC_W-1:0] vec_data;
   logic             vec_ready;
   logic             busy;
   logic             spurious;

   typedef struct {
      logic [VEC_W-1:0] data;
      logic             spur;
   } exp_t;

   typedef struct {
      logic [VEC_W-1:0] d;
      int               ready_delay;
      logic [VEC_W-1:0] exp_data;
   } vec_t;

   exp_t sb_q[$];
   int   n_checks;
   int   n_fail;

   inta_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .INT       (INT),
      .ien       (ien),
      .D         (D),
      .NINTA     (NINTA),
      .vec_valid (vec_valid),
      .vec_data  (vec_data),
      .vec_ready (vec_ready),
      .busy      (busy),
      .spurious  (spurious)
   );

   // 10 ns clock; the bench drives and samples on the falling edge.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case a bounded wait is somehow bypassed.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [VEC_W-1:0] d_val, input logic int_val,
                                input logic ien_val, input logic ready_val);
      D         = d_val;
      INT       = int_val;
      ien       = ien_val;
      vec_ready = ready_val;
   endtask

   task automatic pushExpected(input logic [VEC_W-1:0] data, input logic spur);
      exp_t e;
      e.data = data;
      e.spur = spur;
      sb_q.push_back(e);
   endtask

   task automatic popCompare(input string name);
      exp_t e;
      n_checks++;
      if (sb_q.size() == 0) begin
         n_fail++;
         $display("[TB] FAIL %s: vector %0h arrived, required none pending", name, vec_data);
      end else begin
         e = sb_q.pop_front();
         if (vec_data !== e.data) begin
            n_fail++;
            $display("[TB] FAIL %s: vec_data got %0h, required %0h", name, vec_data, e.data);
         end
         checkOutput({name, "_spurious"}, 32'(spurious), 32'(e.spur));
      end
   endtask

   task automatic waitVector(input string name);
      int cyc;
      cyc = 0;
      while (!vec_valid && cyc < WAIT_LIMIT) begin
         tick();
         cyc++;
      end
      if (!vec_valid) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL %s: vec_valid got 0 after %0d cycles, required 1", name, cyc);
      end else begin
         popCompare(name);
      end
   endtask

   task automatic waitNintaLow(input string name, output int cyc);
      cyc = 0;
      while (NINTA && cyc < WAIT_LIMIT) begin
         tick();
         cyc++;
      end
      if (NINTA) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL %s: NINTA got 1 after %0d cycles, required 0", name, cyc);
      end
   endtask

   task automatic waitIdle(input string name);
      int cyc;
      cyc = 0;
      while (busy && cyc < WAIT_LIMIT) begin
         tick();
         cyc++;
      end
      checkOutput(name, 32'(busy), 32'd0);
   endtask

   task automatic handshake(input string name);
      vec_ready = 1'b1;
      tick();
      checkOutput({name, "_valid_drop"}, 32'(vec_valid), 32'd0);
      checkOutput({name, "_spur_drop"}, 32'(spurious), 32'd0);
      vec_ready = 1'b0;
   endtask

   // One full acknowledge with the request dropped once NINTA first falls,
   // as the PIC would, and the CPU stalling for ready_delay cycles.
   task automatic runAck(input vec_t v, input int idx);
      int cyc;
      applyStimulus(v.d, 1'b1, 1'b1, 1'b0);
      pushExpected(v.exp_data, 1'b0);
      waitNintaLow($sformatf("tbl%0d_first_fall", idx), cyc);
      INT = 1'b0;
      waitVector($sformatf("tbl%0d_vector", idx));
      for (int k = 0; k < v.ready_delay; k++) begin
         tick();
         checkOutput($sformatf("tbl%0d_hold_valid", idx), 32'(vec_valid), 32'd1);
         checkOutput($sformatf("tbl%0d_hold_data", idx), 32'(vec_data), 32'(v.exp_data));
      end
      handshake($sformatf("tbl%0d", idx));
      waitIdle($sformatf("tbl%0d_idle", idx));
   endtask

   initial begin
      vec_t vectors[5];
      logic nin_exp[$];
      int   cyc;

      n_checks = 0;
      n_fail   = 0;

      vectors[0] = '{8'h48, 0, 8'h48};
      vectors[1] = '{8'hA5, 3, 8'hA5};
      vectors[2] = '{8'h00, 1, 8'h00};
      vectors[3] = '{8'hFF, 0, 8'hFF};
      vectors[4] = '{8'h3C, 2, 8'h3C};

      // ---- reset state ----
      reset = 1'b1;
      applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
      tick();
      tick();
      checkOutput("rst_ninta", 32'(NINTA), 32'd1);
      checkOutput("rst_valid", 32'(vec_valid), 32'd0);
      checkOutput("rst_data", 32'(vec_data), 32'h00);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_spurious", 32'(spurious), 32'd0);
      reset = 1'b0;
      tick();

      // ---- basic acknowledge: NINTA waveform from the INT rise ----
      // SYNC cycles of synchronizer latency, then low/high/low, then high.
      for (int i = 0; i < SYNC; i++)  nin_exp.push_back(1'b1);
      for (int i = 0; i < PULSE; i++) nin_exp.push_back(1'b0);
      for (int i = 0; i < GAP; i++)   nin_exp.push_back(1'b1);
      for (int i = 0; i < PULSE; i++) nin_exp.push_back(1'b0);
      nin_exp.push_back(1'b1);

      applyStimulus(8'h48, 1'b1, 1'b1, 1'b0);
      pushExpected(8'h48, 1'b0);
      for (int i = 0; i < nin_exp.size(); i++) begin
         tick();
         checkOutput($sformatf("basic_ninta_c%0d", i + 1), 32'(NINTA), 32'(nin_exp[i]));
         if (i == nin_exp.size() - 1) begin
            checkOutput("basic_valid_rise", 32'(vec_valid), 32'd1);
            if (vec_valid) popCompare("basic_vector");
         end else begin
            checkOutput($sformatf("basic_valid_c%0d", i + 1), 32'(vec_valid), 32'd0);
         end
         if (!NINTA) INT = 1'b0;
      end

      // ---- backpressure: ten stalled cycles, then a one-cycle ready ----
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("bp_valid", 32'(vec_valid), 32'd1);
         checkOutput("bp_data", 32'(vec_data), 32'h48);
         checkOutput("bp_ninta", 32'(NINTA), 32'd1);
      end
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      checkOutput("bp_valid_drop", 32'(vec_valid), 32'd0);
      checkOutput("bp_recover1_busy", 32'(busy), 32'd1);
      tick();
      checkOutput("bp_recover2_busy", 32'(busy), 32'd1);
      tick();
      checkOutput("bp_idle_busy", 32'(busy), 32'd0);

      // ---- table-driven acknowledges ----
      for (int i = 0; i < 5; i++) begin
         runAck(vectors[i], i);
      end

      // ---- enable gating ----
      applyStimulus(8'h5A, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("gate_ninta", 32'(NINTA), 32'd1);
         checkOutput("gate_busy", 32'(busy), 32'd0);
      end
      ien = 1'b1;
      pushExpected(8'h5A, 1'b0);
      tick();
      checkOutput("gate_start_ninta", 32'(NINTA), 32'd0);
      checkOutput("gate_start_busy", 32'(busy), 32'd1);
      INT = 1'b0;
      for (int i = 1; i < PULSE; i++) tick();
      tick();
      checkOutput("gate_g1_ninta", 32'(NINTA), 32'd1);
      ien = 1'b0;
      waitVector("gate_vector");
      handshake("gate");
      waitIdle("gate_idle");
      ien = 1'b1;

      // ---- ready with no vector pending is ignored ----
      vec_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("idle_ready_valid", 32'(vec_valid), 32'd0);
         checkOutput("idle_ready_busy", 32'(busy), 32'd0);
      end
      vec_ready = 1'b0;

      // ---- back-to-back with INT held high ----
      applyStimulus(8'h48, 1'b1, 1'b1, 1'b0);
      pushExpected(8'h48, 1'b0);
      waitVector("b2b_first");
      D = 8'h49;
      pushExpected(8'h49, 1'b0);
      vec_ready = 1'b1;
      tick();
      vec_ready = 1'b0;
      cyc = 0;
      while (NINTA && cyc < WAIT_LIMIT) begin
         tick();
         cyc++;
      end
      checkOutput("b2b_restart_cycles", 32'(cyc), 32'(SYNC + 1));
      INT = 1'b0;
      waitVector("b2b_second");
      handshake("b2b");
      waitIdle("b2b_idle");

      // ---- reset in the middle of P2 ----
      applyStimulus(8'h77, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < SYNC + PULSE + GAP + 1; i++) tick();
      checkOutput("midrst_in_p2_ninta", 32'(NINTA), 32'd0);
      reset = 1'b1;
      INT   = 1'b0;
      #1;
      checkOutput("midrst_ninta", 32'(NINTA), 32'd1);
      checkOutput("midrst_valid", 32'(vec_valid), 32'd0);
      checkOutput("midrst_busy", 32'(busy), 32'd0);
      tick();
      reset = 1'b0;
      for (int i = 0; i < 2 * PULSE + GAP + 2; i++) begin
         tick();
         checkOutput("midrst_after_busy", 32'(busy), 32'd0);
         checkOutput("midrst_after_valid", 32'(vec_valid), 32'd0);
      end

      // ---- withdrawn request: one-cycle INT pulse. The synchronized copy
      // is still high when IDLE commits to P1, but already low during the
      // first P1 cycle, so the pair completes and the vector is flagged. ----
      applyStimulus(8'h4F, 1'b1, 1'b1, 1'b0);
      pushExpected(8'h4F, SPUR_EN);
      tick();
      INT = 1'b0;
      waitVector("spur_vector");
      handshake("spur");
      waitIdle("spur_idle");

      checkOutput("scoreboard_drained", 32'(sb_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
